// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// parameter defaults and instruction field positions.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_UPD  = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int PC_STEP_DEF = 2;
  localparam int TIMEOUT_DEF = 15;

  // Instruction field layout: [15:12] opcode, [11:8] dst, [7:4] src
  localparam int FLD_W   = 4;
  localparam int OPC_LSB = 12;
  localparam int DST_LSB = 8;
  localparam int SRC_LSB = 4;

  // Counter width that holds TIMEOUT, never narrower than 4 bits
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/fetch_unit_timer.sv
// Loadable REQ-phase timeout counter. Held at zero while clr_i is high,
// counts while en_i is high, flags the last permitted cycle on expire_o.
module fetch_timer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // High during the TIMEOUT-th counted cycle; an ack in that cycle still wins
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: latches a fetch address, issues one memory read,
// captures the instruction, and hands the incremented PC to the register
// bank with a write strobe that survives writeback priority.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_STEP = PC_STEP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [DATA_W-1:0] br_target,
  input  logic [DATA_W-1:0] pc_cur,
  input  logic              rf_wr_en,
  output logic [DATA_W-1:0] pc_next,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [FLD_W-1:0]  opcode,
  output logic [FLD_W-1:0]  dst_reg,
  output logic [FLD_W-1:0]  src_reg,
  output logic              fetch_err
);

  localparam int CW = timer_width(TIMEOUT);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              irv_q, irv_d;
  logic [DATA_W-1:0] pcn_q, pcn_d;
  logic              expire;

  // Counter is cleared everywhere outside REQ, so it restarts on every entry
  fetch_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != S_REQ),
    .en_i     (state_q == S_REQ),
    .expire_o (expire)
  );

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    pcn_d   = pcn_q;
    unique case (state_q)
      S_IDLE: if (fetch_en) begin
        addr_d  = br_taken ? br_target : pc_cur;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          irv_d   = 1'b1;
          pcn_d   = addr_q + DATA_W'(PC_STEP);
          state_d = S_UPD;
        end else if (expire) begin
          state_d = S_ERR;
        end
      end
      // Writeback owns the PC port while rf_wr_en is high; keep strobing
      S_UPD:  if (!rf_wr_en) state_d = S_HOLD;
      S_HOLD: if (!stall)    state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      pcn_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      pcn_q   <= pcn_d;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_addr  = addr_q;
  assign pc_inc    = (state_q == S_UPD);
  assign pc_next   = pcn_q;
  assign fetch_err = (state_q == S_ERR);
  assign ir        = ir_q;
  assign ir_valid  = irv_q;
  assign opcode    = ir_q[OPC_LSB +: FLD_W];
  assign dst_reg   = ir_q[DST_LSB +: FLD_W];
  assign src_reg   = ir_q[SRC_LSB +: FLD_W];

endmodule
